// File: rtl/bank_unload_pkg.sv
// Shared FFT constants and index helpers.
// Bit-reverse and bank parity also define how BANK_INIT stores samples.
package bank_unload_pkg;

    localparam int LENGTH = 32;
    localparam int R_DEF  = 5;
    localparam int MAX_R  = 16;

    // Reverses the low w bits of v; bits at and above w come back zero.
    function automatic logic [MAX_R-1:0] bit_rev(
        input logic [MAX_R-1:0] v,
        input int               w
    );
        logic [MAX_R-1:0] src;
        logic [MAX_R-1:0] res;
        src = v;
        res = '0;
        for (int i = 0; i < MAX_R; i++) begin
            if (i < w) begin
                res = {res[MAX_R-2:0], src[0]};
                src = src >> 1;
            end
        end
        return res;
    endfunction

    function automatic logic bank_parity(input logic [MAX_R-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/bank_unload_if.sv
// Bank read ports, controller handshake and output stream of the unloader.
// master = unloader side, slave = banks/controller/downstream side.
interface bank_unload_if #(
    parameter int length = 32,
    parameter int R      = 5
);
    logic                  i_BU_en;
    logic                  o_BU_done;
    logic [R-2:0]          o_m0_addr;
    logic [R-2:0]          o_m1_addr;
    logic                  o_m0_r_en;
    logic                  o_m1_r_en;
    logic [2*length-1:0]   i_m0_data;
    logic [2*length-1:0]   i_m1_data;
    logic [2*length-1:0]   o_data;
    logic [R-1:0]          o_index;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        input  i_BU_en, i_m0_data, i_m1_data, i_ready,
        output o_BU_done, o_m0_addr, o_m1_addr, o_m0_r_en,
        output o_m1_r_en, o_data, o_index, o_valid
    );

    modport slave (
        output i_BU_en, i_m0_data, i_m1_data, i_ready,
        input  o_BU_done, o_m0_addr, o_m1_addr, o_m0_r_en,
        input  o_m1_r_en, o_data, o_index, o_valid
    );
endinterface

// File: rtl/bank_unload_addr_map.sv
// Maps unload counter k to natural index n, bank select and word address.
module bank_unload_addr_map
    import bank_unload_pkg::*;
#(
    parameter int R       = 5,
    parameter int BIT_REV = 1
) (
    input  logic [R-1:0] k,
    output logic [R-1:0] n,
    output logic         sel,
    output logic [R-2:0] addr
);
    logic [MAX_R-1:0] ext;
    logic [MAX_R-1:0] nat;

    always_comb begin
        ext        = '0;
        ext[R-1:0] = k;
        nat        = (BIT_REV != 0) ? bit_rev(ext, R) : ext;
        n          = nat[R-1:0];
        sel        = bank_parity(nat);
        addr       = nat[R-2:0];
    end
endmodule

// File: rtl/bank_unload.sv
// Streams an FFT result out of two parity-interleaved banks,
// one sample per read/capture/handshake round.
module bank_unload
    import bank_unload_pkg::*;
#(
    parameter int length  = 32,
    parameter int R       = 5,
    parameter int BIT_REV = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    bank_unload_if.master bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_OUT     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [R-1:0] K_LAST = '1;

    state_e              state_q, state_d;
    logic [R-1:0]        k_q, k_d;
    logic [R-2:0]        m0_addr_q, m0_addr_d;
    logic [R-2:0]        m1_addr_q, m1_addr_d;
    logic                m0_r_en_q, m0_r_en_d;
    logic                m1_r_en_q, m1_r_en_d;
    logic [2*length-1:0] data_q, data_d;
    logic [R-1:0]        index_q, index_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    logic [R-1:0]        k_rd;
    logic [R-1:0]        map_n;
    logic                map_sel;
    logic [R-2:0]        map_addr;
    logic                issue;

    // Index of the sample whose read would be issued at the next edge.
    always_comb begin
        case (state_q)
            ST_IDLE: k_rd = '0;
            ST_OUT:  k_rd = k_q + 1'b1;
            default: k_rd = k_q;
        endcase
    end

    bank_unload_addr_map #(
        .R       (R),
        .BIT_REV (BIT_REV)
    ) u_map (
        .k    (k_rd),
        .n    (map_n),
        .sel  (map_sel),
        .addr (map_addr)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        m0_addr_d = m0_addr_q;
        m1_addr_d = m1_addr_q;
        m0_r_en_d = 1'b0;
        m1_r_en_d = 1'b0;
        data_d    = data_q;
        index_d   = index_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        issue     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_BU_en) begin
                    state_d = ST_RD_ADDR;
                    k_d     = '0;
                    issue   = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                data_d  = map_sel ? bus.i_m1_data : bus.i_m0_data;
                index_d = map_n;
                valid_d = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (valid_q && bus.i_ready) begin
                    valid_d = 1'b0;
                    if (k_q == K_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_RD_ADDR;
                        issue   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                k_d     = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read enable is registered on entry to ST_RD_ADDR.
        if (issue) begin
            if (map_sel) begin
                m1_r_en_d = 1'b1;
                m1_addr_d = map_addr;
            end else begin
                m0_r_en_d = 1'b1;
                m0_addr_d = map_addr;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            m0_addr_q <= '0;
            m1_addr_q <= '0;
            m0_r_en_q <= 1'b0;
            m1_r_en_q <= 1'b0;
            data_q    <= '0;
            index_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            m0_addr_q <= m0_addr_d;
            m1_addr_q <= m1_addr_d;
            m0_r_en_q <= m0_r_en_d;
            m1_r_en_q <= m1_r_en_d;
            data_q    <= data_d;
            index_q   <= index_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_BU_done = done_q;
    assign bus.o_m0_addr = m0_addr_q;
    assign bus.o_m1_addr = m1_addr_q;
    assign bus.o_m0_r_en = m0_r_en_q;
    assign bus.o_m1_r_en = m1_r_en_q;
    assign bus.o_data    = data_q;
    assign bus.o_index   = index_q;
    assign bus.o_valid   = valid_q;
endmodule

// File: tb/tb_bank_unload.sv
// Random-data bench for bank_unload: natural-order and bit-reversed
// instances run in lockstep against an index-level reference model.
module tb_bank_unload;

    localparam int LEN = 32;
    localparam int RR  = 5;
    localparam int NN  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_e = 1'b1;
    logic en = 1'b0;
    logic ready = 1'b1;

    logic [63:0] sample [NN];

    int n_checks = 0;
    int n_errors = 0;

    int rd_total [2];
    int acc_total [2];
    int done_total [2];
    logic v_mon [2];
    logic d_mon [2];

    always #5 clk = ~clk;
    always @(posedge clk) rst_e <= rst;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_n(input int k, input int brev);
        int r;
        if (brev == 0) return k;
        r = 0;
        for (int i = 0; i < RR; i++)
            if (((k >> i) & 1) == 1) r += 1 << (RR - 1 - i);
        return r;
    endfunction

    function automatic int parity(input int n);
        int c;
        c = 0;
        for (int i = 0; i < RR; i++) c += (n >> i) & 1;
        return c % 2;
    endfunction

    // Sample stored at word a of bank b: the index with that low part
    // whose ones-count parity equals b.
    function automatic int bank_n(input int b, input int a);
        return a + (NN / 2) * ((b + parity(a)) % 2);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bank_unload_if #(.length(LEN), .R(RR)) ifc ();

        bank_unload #(.length(LEN), .R(RR), .BIT_REV(g)) dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (ifc.master)
        );

        logic [63:0] m0_q = '0;
        logic [63:0] m1_q = '0;

        always @(posedge clk) begin
            if (ifc.o_m0_r_en) m0_q <= sample[bank_n(0, int'(ifc.o_m0_addr))];
            if (ifc.o_m1_r_en) m1_q <= sample[bank_n(1, int'(ifc.o_m1_addr))];
        end

        assign ifc.i_m0_data = m0_q;
        assign ifc.i_m1_data = m1_q;
        assign ifc.i_BU_en   = en;
        assign ifc.i_ready   = ready;
        assign v_mon[g]      = ifc.o_valid;
        assign d_mon[g]      = ifc.o_BU_done;

        int k_exp = 0;
        int rd_cnt = 0;
        int nn;
        logic hold = 1'b0;
        logic [63:0] hd;
        logic [4:0] hi;

        always @(negedge clk) begin
            if (rst_e) begin
                check("rst_data", ifc.o_data, 0);
                check("rst_ctl", {ifc.o_BU_done, ifc.o_m0_addr, ifc.o_m1_addr,
                                  ifc.o_m0_r_en, ifc.o_m1_r_en, ifc.o_index,
                                  ifc.o_valid}, 0);
                k_exp = 0;
                rd_cnt = 0;
                hold = 1'b0;
            end else begin
                if (ifc.o_m0_r_en || ifc.o_m1_r_en) begin
                    nn = ref_n(rd_cnt % NN, g);
                    check("rd_one_bank", ifc.o_m0_r_en & ifc.o_m1_r_en, 0);
                    check("rd_bank", ifc.o_m1_r_en, parity(nn));
                    check("rd_addr", ifc.o_m1_r_en ? ifc.o_m1_addr : ifc.o_m0_addr,
                          nn % (NN / 2));
                    check("rd_while_valid", ifc.o_valid, 0);
                    rd_cnt++;
                    rd_total[g]++;
                end
                if (ifc.o_valid) begin
                    if (hold) begin
                        check("hold_data", ifc.o_data, hd);
                        check("hold_index", ifc.o_index, hi);
                    end
                    if (ready && !rst) begin
                        nn = ref_n(k_exp % NN, g);
                        check("out_index", ifc.o_index, nn);
                        check("out_data", ifc.o_data, sample[nn]);
                        k_exp++;
                        acc_total[g]++;
                        hold = 1'b0;
                    end else begin
                        hold = 1'b1;
                        hd = ifc.o_data;
                        hi = ifc.o_index;
                    end
                end
                if (ifc.o_BU_done) begin
                    check("done_count", k_exp, NN);
                    done_total[g]++;
                    k_exp = 0;
                    rd_cnt = 0;
                end
            end
        end
    end

    task automatic fill_samples();
        for (int i = 0; i < NN; i++) sample[i] = {$urandom, $urandom};
    endtask

    // Starts one unload and runs it to o_BU_done or a cycle bound.
    task automatic run_unload(input bit rnd, input bit extra,
                              output int fv, output int fd);
        int cyc;
        int acc0;
        int bp_left;
        bit bp_done;
        bit pulsed;
        cyc = 0; fv = 0; fd = 0;
        bp_left = 0; bp_done = 0; pulsed = 0;
        acc0 = acc_total[0];
        if (!rnd) ready = 1'b1;
        en = 1'b1;
        while (fd == 0 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
            en = 1'b0;
            if (v_mon[0] && fv == 0) fv = cyc;
            if (d_mon[0]) fd = cyc;
            if (extra && !bp_done && v_mon[0] && acc_total[0] - acc0 == 7) begin
                ready = 1'b0;
                bp_left = 4;
                bp_done = 1;
            end else if (bp_left > 0) begin
                ready = 1'b0;
                bp_left--;
            end else begin
                ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (extra && !pulsed && acc_total[0] - acc0 == 4) begin
                en = 1'b1;
                pulsed = 1;
            end
            if (extra && d_mon[0]) en = 1'b1;
        end
        check("unload_timeout", fd != 0, 1);
        if (extra) check("bp_applied", bp_done, 1);
    endtask

    initial begin
        int fv, fd, acc0, dn0, rd0, cyc;
        for (int g = 0; g < 2; g++) begin
            rd_total[g] = 0;
            acc_total[g] = 0;
            done_total[g] = 0;
        end
        fill_samples();

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_read", rd_total[0] + rd_total[1], 0);
        check("idle_no_valid", {v_mon[0], v_mon[1]}, 0);

        // Full-rate unload: latency and throughput
        run_unload(0, 0, fv, fd);
        check("lat_first_valid", fv, 3);
        check("lat_done", fd, 3 * NN + 1);
        @(posedge clk);
        #1;
        check("done_pulse_width", {d_mon[0], d_mon[1]}, 0);
        repeat (3) @(posedge clk);
        for (int g = 0; g < 2; g++) begin
            check("runA_acc", acc_total[g], NN);
            check("runA_done", done_total[g], 1);
            check("runA_reads", rd_total[g], NN);
        end

        // Random backpressure plus ignored i_BU_en pulses
        fill_samples();
        acc0 = acc_total[0];
        dn0 = done_total[0];
        rd0 = rd_total[0];
        run_unload(1, 1, fv, fd);
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("runB_acc", acc_total[g] - acc0, NN);
            check("runB_done", done_total[g] - dn0, 1);
            check("runB_reads", rd_total[g] - rd0, NN);
        end

        // Reset while sample k=10 waits in the output stage
        fill_samples();
        acc0 = acc_total[0];
        ready = 1'b1;
        en = 1'b1;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            en = 1'b0;
            if (v_mon[0] && acc_total[0] - acc0 == 10) begin
                ready = 1'b0;
                rst = 1'b1;
                break;
            end
        end
        check("rst_k10_reached", rst, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_k10_valid", {v_mon[0], v_mon[1]}, 0);
        rd0 = rd_total[0];
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_quiet", rd_total[0] - rd0, 0);
        acc0 = acc_total[0];
        dn0 = done_total[0];
        run_unload(1, 0, fv, fd);
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            check("runC_acc", acc_total[g] - acc0, NN);
            check("runC_done", done_total[g] - dn0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
